// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB per instruction,
// latches decoded datapath selects once per instruction, and traps on bad encodings or memory timeout.
module mc_control_fsm #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4,
  parameter int ALU_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_type,
  input  logic             i_type,
  input  logic             load,
  input  logic             store,
  input  logic             branch,
  input  logic             jal,
  input  logic             jalr,
  input  logic             lui,
  input  logic             auipc,
  input  logic [2:0]       fun3,
  input  logic             fun7,
  input  logic             mem_ack,
  input  logic             br_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_en,
  output logic             pc_en,
  output logic             next_sel,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             operand_a,
  output logic             operand_b,
  output logic [2:0]       imm_sel,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(4'h0);
  localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(4'h1);
  localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(4'h2);
  localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(4'h3);
  localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(4'h4);
  localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(4'h5);
  localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(4'h6);
  localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(4'h7);
  localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(4'h8);
  localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(4'h9);
  localparam logic [ALU_W-1:0] ALU_PASSB = ALU_W'(4'hF);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             run_q;
  logic [ALU_W-1:0] alu_q, alu_d;
  logic [2:0]       imm_q, imm_d;
  logic             opa_q, opa_d;
  logic             opb_q, opb_d;
  logic [1:0]       m2r_q, m2r_d;
  logic             ld_q, ld_d;
  logic             st_q, st_d;
  logic             br_q, br_d;
  logic             jmp_q, jmp_d;

  logic [8:0]       cls_flags;
  logic [ALU_W-1:0] dec_alu;
  logic [2:0]       dec_imm;
  logic             dec_opa;
  logic             dec_opb;
  logic [1:0]       dec_m2r;
  logic             dec_bad;
  logic             sel_on;

  // funct3 -> ALU op; alt selects sub/sra, sub only exists for register-register ops
  function automatic logic [ALU_W-1:0] arith_op(input logic [2:0] f3, input logic alt,
                                                input logic allow_sub);
    logic [ALU_W-1:0] res;
    res = ALU_ADD;
    case (f3)
      3'b000:  res = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  res = ALU_SLL;
      3'b010:  res = ALU_SLT;
      3'b011:  res = ALU_SLTU;
      3'b100:  res = ALU_XOR;
      3'b101:  res = alt ? ALU_SRA : ALU_SRL;
      3'b110:  res = ALU_OR;
      default: res = ALU_AND;
    endcase
    return res;
  endfunction

  assign cls_flags = {r_type, i_type, load, store, branch, jal, jalr, lui, auipc};

  always_comb begin
    dec_alu = ALU_ADD;
    dec_imm = IMM_I;
    dec_opa = 1'b0;
    dec_opb = 1'b1;
    dec_m2r = M2R_ALU;
    dec_bad = !$onehot(cls_flags);
    if (r_type) begin
      dec_opb = 1'b0;
      dec_alu = arith_op(fun3, fun7, 1'b1);
      if (fun7 && (fun3 != 3'b000) && (fun3 != 3'b101)) dec_bad = 1'b1;
    end else if (i_type) begin
      dec_alu = arith_op(fun3, fun7, 1'b0);
      if (fun7 && (fun3 == 3'b001)) dec_bad = 1'b1;
    end else if (load) begin
      dec_m2r = M2R_MEM;
      if ((fun3 == 3'b011) || (fun3[2:1] == 2'b11)) dec_bad = 1'b1;
    end else if (store) begin
      dec_imm = IMM_S;
      if (fun3 > 3'b010) dec_bad = 1'b1;
    end else if (branch) begin
      dec_imm = IMM_B;
      dec_opa = 1'b1;
      if (fun3[2:1] == 2'b01) dec_bad = 1'b1;
    end else if (jal) begin
      dec_imm = IMM_J;
      dec_opa = 1'b1;
      dec_m2r = M2R_PC4;
    end else if (jalr) begin
      dec_m2r = M2R_PC4;
    end else if (lui) begin
      dec_imm = IMM_U;
      dec_alu = ALU_PASSB;
    end else if (auipc) begin
      dec_imm = IMM_U;
      dec_opa = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_d     = alu_q;
    imm_d     = imm_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    m2r_d     = m2r_q;
    ld_d      = ld_q;
    st_d      = st_q;
    br_d      = br_q;
    jmp_d     = jmp_q;
    sel_on    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    next_sel  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        // run_q keeps the bus quiet from reset until the first clock edge after release
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_en   = 1'b1;
            cnt_d   = '0;
            state_d = S_DECODE;
          end else if (cnt_q == TO_LAST) begin
            cnt_d   = '0;
            state_d = S_TRAP;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
      end
      S_DECODE: begin
        alu_d   = dec_alu;
        imm_d   = dec_imm;
        opa_d   = dec_opa;
        opb_d   = dec_opb;
        m2r_d   = dec_m2r;
        ld_d    = load;
        st_d    = store;
        br_d    = branch;
        jmp_d   = jal | jalr;
        state_d = dec_bad ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        sel_on = 1'b1;
        if (br_q) begin
          pc_en    = 1'b1;
          next_sel = br_taken;
          state_d  = S_FETCH;
        end else if (ld_q || st_q) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        sel_on  = 1'b1;
        mem_req = 1'b1;
        mem_we  = st_q;
        if (mem_ack) begin
          cnt_d = '0;
          // a store retires in its ack cycle, so pc_en overlaps the still-held request
          if (st_q) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_WB: begin
        sel_on    = 1'b1;
        reg_write = 1'b1;
        pc_en     = 1'b1;
        next_sel  = jmp_q;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
    alu_control = sel_on ? alu_q : '0;
    imm_sel     = sel_on ? imm_q : '0;
    operand_a   = sel_on & opa_q;
    operand_b   = sel_on & opb_q;
    mem_to_reg  = sel_on ? m2r_q : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      alu_q   <= '0;
      imm_q   <= '0;
      opa_q   <= 1'b0;
      opb_q   <= 1'b0;
      m2r_q   <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      br_q    <= 1'b0;
      jmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      m2r_q   <= m2r_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      br_q    <= br_d;
      jmp_q   <= jmp_d;
    end
  end

  assign state = state_q;

endmodule
